// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding a first-word-fall-through byte FIFO
module uart_rx_fifo #(
  parameter int CLK_FREQ_HZ = 10_000_000,
  parameter int BAUD_RATE   = 1_000_000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        rxd_i,
  input  logic                        rd_i,
  input  logic                        clr_err_i,
  output logic [7:0]                  data_o,
  output logic                        valid_o,
  output logic [$clog2(FIFO_DEPTH):0] count_o,
  output logic                        overrun_o,
  output logic                        frame_err_o,
  output logic                        parity_err_o
);

  localparam int DIV    = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W  = $clog2(DIV) + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  HALF_LOAD = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_LOAD = CNT_W'(DIV - 1);
  localparam logic [FCNT_W-1:0] DEPTH     = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_RX_PARITY_EN
    ,
    S_PARITY
`endif
  } state_e;

  // Receiver state
  logic [1:0]       sync_q, sync_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             rxs;
  logic             tick;
  logic             push;
  logic             frame_set;
  logic             par_set;
`ifdef UART_RX_PARITY_EN
  logic             par_bad_q, par_bad_d;
`endif

  // FIFO state
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0] count_q, count_d;
  logic              pop;
  logic              full;
  logic              push_ok;
  logic              ovr_set;

  // Sticky error flags
  logic overrun_q, overrun_d;
  logic frame_err_q, frame_err_d;
  logic parity_err_q, parity_err_d;

  assign rxs  = sync_q[1];
  assign tick = (cnt_q == '0);

  // Receive FSM next state: half-bit wait to the start-bit centre, then one full bit per sample
  always_comb begin
    sync_d    = {sync_q[0], rxd_i};
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
    par_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d = S_START;
          cnt_d   = HALF_LOAD;
        end
      end
      S_START: begin
        if (tick) begin
          if (rxs) begin
            // Line went back high before the start-bit centre: treat as a glitch
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = FULL_LOAD;
            bit_d   = 3'd0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = {rxs, shift_q[7:1]};
          cnt_d   = FULL_LOAD;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          // Even parity: the parity bit must equal the XOR of the data bits
          par_bad_d = rxs ^ (^shift_q);
          cnt_d     = FULL_LOAD;
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          // Leave at the stop-bit centre so a back-to-back start edge is not missed
          state_d   = S_IDLE;
          frame_set = !rxs;
`ifdef UART_RX_PARITY_EN
          par_set   = par_bad_q;
          push      = rxs && !par_bad_q;
`else
          push      = rxs;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO bookkeeping: pop is applied first, so a full FIFO can accept a push in a popping cycle
  always_comb begin
    pop      = rd_i && (count_q != '0);
    full     = (count_q == DEPTH);
    push_ok  = push && (!full || pop);
    ovr_set  = push && full && !pop;
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + FCNT_W'(1);
    end else if (pop && !push_ok) begin
      count_d = count_q - FCNT_W'(1);
    end
  end

  // Sticky flags: a set event in the clearing cycle wins
  always_comb begin
    overrun_d    = ovr_set   | (overrun_q    & ~clr_err_i);
    frame_err_d  = frame_set | (frame_err_q  & ~clr_err_i);
    parity_err_d = par_set   | (parity_err_q & ~clr_err_i);
  end

  // All control state, with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sync_q       <= 2'b11;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= 3'd0;
      shift_q      <= 8'h00;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
`endif
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
`endif
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  // Byte storage; contents need no reset because the head is masked when empty
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign valid_o      = (count_q != '0);
  assign count_o      = count_q;
  assign data_o       = valid_o ? mem_q[rd_ptr_q] : 8'h00;
  assign overrun_o    = overrun_q;
  assign frame_err_o  = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - randomized self-checking bench for uart_rx_fifo against a queue-based model
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int DIV = 10;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = DIV * FRAME_BITS;
  localparam int PUSH_AT   = FRAME_CYC - 3;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       rxd_i;
  logic       rd_i;
  logic       clr_err_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic [2:0] count_o;
  logic       overrun_o;
  logic       frame_err_o;
  logic       parity_err_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] mq[$];
  bit m_ovr, m_frm, m_par;
  int first_valid;

  uart_rx_fifo #(
    .CLK_FREQ_HZ(10_000_000),
    .BAUD_RATE  (1_000_000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .rxd_i       (rxd_i),
    .rd_i        (rd_i),
    .clr_err_i   (clr_err_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .count_o     (count_o),
    .overrun_o   (overrun_o),
    .frame_err_o (frame_err_o),
    .parity_err_o(parity_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Line level during cycle i of a frame: start, 8 data LSB first, [parity], stop
  function automatic logic line_level(input logic [7:0] b, input int i, input logic stop, input logic par);
    int idx;
    idx = i / DIV;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (FRAME_BITS == 11 && idx == 9) return par;
    if (idx == FRAME_BITS - 1) return stop;
    return 1'b1;
  endfunction

  // Reference: what one complete frame does to the byte queue and the flags
  task automatic model_frame(input logic [7:0] b, input logic stop, input logic par, input bit pop_at_push);
    bit par_ok;
    par_ok = (FRAME_BITS == 10) || (par == ^b);
    if (pop_at_push && mq.size() > 0) void'(mq.pop_front());
    if (!stop) m_frm = 1'b1;
    if (!par_ok) m_par = 1'b1;
    if (stop && par_ok) begin
      if (mq.size() < 4) mq.push_back(b);
      else m_ovr = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par, input int rd_at, input int gap);
    bit v0;
    v0 = valid_o;
    first_valid = -1;
    for (int i = 0; i < FRAME_CYC; i++) begin
      rxd_i = line_level(b, i, stop, par);
      rd_i  = (i == rd_at);
      @(posedge clk_i);
      #1;
      if (!v0 && valid_o && first_valid < 0) first_valid = i + 1;
    end
    rd_i  = 1'b0;
    rxd_i = 1'b1;
    model_frame(b, stop, par, rd_at >= 0);
    repeat (gap) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, count_o, mq.size());
    check({tag, "_valid"}, valid_o, mq.size() != 0);
    check({tag, "_data"}, data_o, mq.size() != 0 ? mq[0] : 8'h00);
    check({tag, "_ovr"}, overrun_o, m_ovr);
    check({tag, "_frm"}, frame_err_o, m_frm);
    check({tag, "_par"}, parity_err_o, m_par);
  endtask

  task automatic pop_one(input string tag);
    check({tag, "_head"}, data_o, mq.size() != 0 ? mq[0] : 8'h00);
    rd_i = 1'b1;
    @(posedge clk_i);
    #1;
    rd_i = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic clear_flags();
    clr_err_i = 1'b1;
    @(posedge clk_i);
    #1;
    clr_err_i = 1'b0;
    m_ovr = 1'b0;
    m_frm = 1'b0;
    m_par = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    logic       stop;
    logic       par;
    reset_i   = 1'b0;
    rxd_i     = 1'b1;
    rd_i      = 1'b0;
    clr_err_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_state("reset");
    reset_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;

    // Single byte and its latency from the start edge
    send_frame(8'h55, 1'b1, ^8'h55, -1, 10);
    check("latency_in_window", (first_valid >= 94 && first_valid <= 100 + DIV * (FRAME_BITS - 10)), 1);
    check_state("single");
    pop_one("single_pop");
    check_state("single_after_pop");

    // Short low pulse must be rejected without side effects
    rxd_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rxd_i = 1'b1;
    repeat (20) @(posedge clk_i);
    #1;
    check_state("glitch");

    // Framing error, clear, then a good byte
    send_frame(8'hA5, 1'b0, ^8'hA5, -1, 20);
    check_state("frame_err");
    clear_flags();
    check_state("frame_clr");
    send_frame(8'h3C, 1'b1, ^8'h3C, -1, 10);
    check_state("after_frame_err");
    pop_one("after_frame_err_pop");

    // Overrun: five back-to-back bytes, no reads
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1, ^8'(k), -1, 0);
    repeat (20) @(posedge clk_i);
    #1;
    check_state("overrun");
    for (int k = 0; k < 4; k++) pop_one("overrun_pop");
    check_state("overrun_drained");
    clear_flags();

    // Full FIFO with a pop exactly on the fifth push cycle
    for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b1, ^8'(k), -1, 0);
    send_frame(8'h05, 1'b1, ^8'h05, PUSH_AT, 20);
    check_state("full_pop_push");
    for (int k = 0; k < 4; k++) pop_one("full_pop_push_pop");
    check_state("full_pop_push_drained");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h03, 1'b1, 1'b0, -1, 10);
    check_state("parity_good");
    send_frame(8'h03, 1'b1, 1'b1, -1, 10);
    check_state("parity_bad");
    pop_one("parity_pop");
    clear_flags();
`endif

    // Reset in the middle of data bit 4 with two bytes queued
    send_frame(8'h11, 1'b1, ^8'h11, -1, 0);
    send_frame(8'h22, 1'b1, ^8'h22, -1, 0);
    check_state("pre_reset");
    for (int i = 0; i < 5 * DIV + 5; i++) begin
      rxd_i = line_level(8'h5A, i, 1'b1, ^8'h5A);
      @(posedge clk_i);
      #1;
    end
    reset_i = 1'b0;
    #1;
    mq.delete();
    m_ovr = 1'b0;
    m_frm = 1'b0;
    m_par = 1'b0;
    check_state("mid_reset");
    @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    rxd_i   = 1'b1;
    repeat (20) @(posedge clk_i);
    #1;
    send_frame(8'h7E, 1'b1, ^8'h7E, -1, 10);
    check_state("after_reset");
    pop_one("after_reset_pop");

    // Randomized frames, errors and reads against the model
    for (int n = 0; n < 16; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      par  = (^b) ^ ($urandom_range(0, 4) == 0);
      send_frame(b, stop, par, -1, 20);
      check_state("rand");
      for (int p = $urandom_range(0, 2); p > 0; p--) pop_one("rand_pop");
      if ($urandom_range(0, 3) == 0) clear_flags();
    end
    check_state("rand_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
